// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a small valid/ready FIFO of received bytes.
// rxd is asynchronous; it is synchronised by two flops before the frame FSM sees it.
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned LEVEL_W      = 3
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               rxd,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               frame_err,
    output logic               overflow,
    input  logic               clr_overflow,
    output logic [LEVEL_W-1:0] level
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0]   CNT_MID    = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic             rxd_m;
    logic             rxd_s;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_nxt;
    logic [7:0]       shift;
    logic [7:0]       shift_nxt;
    logic             push_c;
    logic             ferr_c;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   rd_nxt_c;
    logic [LEVEL_W-1:0] level_nxt_c;
    logic [7:0]         head_nxt_c;
    logic               pop_c;
    logic               full_c;
    logic               wr_en_c;
    logic               ovf_set_c;

    // Two-flop synchroniser, idle-high reset value
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_nxt;
            shift     <= shift_nxt;
            frame_err <= ferr_c;
        end
    end

    // Frame decoder: start confirmed at mid-bit, data and stop sampled at bit end
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        push_c    = 1'b0;
        ferr_c    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rxd_s) begin
                    state_nxt = S_START;
                    cnt_nxt   = '0;
                end
            end
            S_START: begin
                if (cnt == CNT_MID) begin
                    cnt_nxt = '0;
                    if (!rxd_s) begin
                        state_nxt = S_DATA;
                        bit_nxt   = '0;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    shift_nxt = {rxd_s, shift[7:1]};
                    bit_nxt   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = S_STOP;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                    if (rxd_s) begin
                        push_c = 1'b1;
                    end else begin
                        ferr_c = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign pop_c     = out_valid && out_ready;
    assign full_c    = (level == LEVEL_FULL);
    assign wr_en_c   = push_c && (!full_c || pop_c);
    assign ovf_set_c = push_c && full_c && !pop_c;
    assign rd_nxt_c  = pop_c ? rd_ptr + PTR_W'(1) : rd_ptr;

    // A byte written into the slot that becomes the head must bypass the array
    assign head_nxt_c = (wr_en_c && (wr_ptr == rd_nxt_c)) ? shift : mem[rd_nxt_c];

    always_comb begin
        level_nxt_c = level;
        case ({wr_en_c, pop_c})
            2'b10:   level_nxt_c = level + LEVEL_W'(1);
            2'b01:   level_nxt_c = level - LEVEL_W'(1);
            default: level_nxt_c = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn && wr_en_c) begin
            mem[wr_ptr] <= shift;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (wr_en_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr    <= rd_nxt_c;
            level     <= level_nxt_c;
            out_valid <= (level_nxt_c != '0);
            if (level_nxt_c != '0) begin
                out_data <= head_nxt_c;
            end
            // Set has priority over a same-cycle clear
            if (ovf_set_c) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a queue-level model predicts delivered bytes,
// occupancy, frame_err and overflow from frame timing; a monitor compares every cycle.
module tb_uart_rx_fifo;
    localparam int CPB   = 8;
    localparam int DEPTH = 4;
    localparam int PUSH_DELAY = 3 + CPB / 2 + 9 * CPB;

    typedef struct {
        logic [7:0] data;
        bit         good;
        int         at;
    } pend_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic       rxd;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       frame_err;
    logic       overflow;
    logic       clr_overflow;
    logic [2:0] level;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_popped = 0;
    int ready_mode = 1;
    int ready_at   = 0;

    logic [7:0] sb_q [$];
    pend_t      pend_q [$];
    int         m_level = 0;
    bit         m_ferr  = 1'b0;
    bit         m_ovf   = 1'b0;

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .LEVEL_W     (3)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .rxd         (rxd),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .frame_err   (frame_err),
        .overflow    (overflow),
        .clr_overflow(clr_overflow),
        .level       (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: acts on frame completion times and the sampled handshake inputs
    always @(posedge clk) begin
        bit         pop_m;
        bit         set_m;
        pend_t      p;
        cyc++;
        m_ferr = 1'b0;
        if (!resetn) begin
            m_level = 0;
            m_ovf   = 1'b0;
            sb_q.delete();
            pend_q.delete();
        end else begin
            pop_m = (m_level > 0) && out_ready;
            set_m = 1'b0;
            if (pend_q.size() > 0 && pend_q[0].at == cyc) begin
                p = pend_q.pop_front();
                if (!p.good) begin
                    m_ferr = 1'b1;
                end else if (m_level < DEPTH || pop_m) begin
                    sb_q.push_back(p.data);
                    m_level++;
                end else begin
                    set_m = 1'b1;
                end
            end
            if (pop_m) m_level--;
            if (set_m) m_ovf = 1'b1;
            else if (clr_overflow) m_ovf = 1'b0;
        end
    end

    // Monitor: status every cycle, head byte while valid, pop on handshake
    always @(negedge clk) begin
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_level != 0));
        chk("level", 32'(level), 32'(m_level));
        chk("frame_err", 32'(frame_err), 32'(m_ferr));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (out_valid && sb_q.size() > 0) chk("out_data", 32'(out_data), 32'(sb_q[0]));
        if (out_valid && out_ready) begin
            chk("pop_expected", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            n_popped++;
        end
    end

    // out_ready driver: 0 off, 1 on, 2 random, 3 high from edge ready_at onward
    always @(negedge clk) begin
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            2:       out_ready = 1'($urandom);
            default: out_ready = (cyc + 1 >= ready_at);
        endcase
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit good, input int nbits);
        logic [9:0] bits;
        pend_t      p;
        bits = {good, b, 1'b0};
        if (nbits == 10) begin
            p.data = b;
            p.good = good;
            p.at   = cyc + PUSH_DELAY;
            pend_q.push_back(p);
        end
        for (int i = 0; i < nbits; i++) begin
            rxd = bits[i];
            repeat (CPB) @(negedge clk);
        end
        if (nbits == 10) rxd = 1'b1;
    endtask

    initial begin
        int p0;
        resetn       = 1'b0;
        rxd          = 1'b1;
        clr_overflow = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_level", 32'(level), 32'h0);
        resetn = 1'b1;
        idle(5);

        // Single byte, always ready
        p0 = n_popped;
        send_frame(8'hA5, 1'b1, 10);
        idle(2 * CPB);
        chk("t1_pops", 32'(n_popped - p0), 32'd1);

        // Fill, overflow, drain, clear
        ready_mode = 0;
        p0 = n_popped;
        for (int i = 1; i <= 5; i++) begin
            send_frame((i == 5) ? 8'h55 : 8'(i), 1'b1, 10);
            idle(CPB + 4);
        end
        chk("t2_level_full", 32'(level), 32'd4);
        chk("t2_overflow_set", 32'(overflow), 32'd1);
        ready_mode = 1;
        idle(10);
        chk("t2_pops", 32'(n_popped - p0), 32'd4);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        @(negedge clk);
        chk("t2_overflow_clr", 32'(overflow), 32'd0);

        // Framing error then a good frame
        p0 = n_popped;
        send_frame(8'h3C, 1'b0, 10);
        idle(2 * CPB);
        send_frame(8'h7E, 1'b1, 10);
        idle(2 * CPB);
        chk("t3_pops", 32'(n_popped - p0), 32'd1);

        // Start glitch then 0xFF
        p0 = n_popped;
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        idle(2 * CPB);
        send_frame(8'hFF, 1'b1, 10);
        idle(2 * CPB);
        chk("t4_pops", 32'(n_popped - p0), 32'd1);

        // Full FIFO, ready rises in the exact push cycle
        ready_mode = 0;
        p0 = n_popped;
        for (int i = 0; i < 4; i++) begin
            send_frame(8'($urandom), 1'b1, 10);
            idle(CPB + 4);
        end
        ready_at   = cyc + PUSH_DELAY;
        ready_mode = 3;
        send_frame(8'($urandom), 1'b1, 10);
        idle(10);
        chk("t5_pops", 32'(n_popped - p0), 32'd5);
        chk("t5_overflow", 32'(overflow), 32'd0);

        // Reset mid-DATA with a byte queued
        ready_mode = 0;
        send_frame(8'h11, 1'b1, 10);
        idle(CPB + 4);
        chk("t6_level_pre", 32'(level), 32'd1);
        send_frame(8'h5A, 1'b1, 4);
        resetn = 1'b0;
        rxd    = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        chk("t6_rst_out_data", 32'(out_data), 32'h0);
        chk("t6_rst_level", 32'(level), 32'h0);
        chk("t6_rst_valid", 32'(out_valid), 32'h0);
        chk("t6_rst_ferr", 32'(frame_err), 32'h0);
        idle(12 * CPB);
        chk("t6_no_ghost", 32'(level), 32'h0);
        ready_mode = 1;
        p0 = n_popped;
        send_frame(8'h5A, 1'b1, 10);
        idle(2 * CPB);
        chk("t6_pops", 32'(n_popped - p0), 32'd1);

        // Randomised frames, stop bits, ready patterns and overflow clears
        for (int i = 0; i < 14; i++) begin
            ready_mode = $urandom_range(0, 2);
            send_frame(8'($urandom), ($urandom_range(0, 7) != 0), 10);
            idle(CPB + $urandom_range(0, 2 * CPB));
            if ($urandom_range(0, 3) == 0) begin
                clr_overflow = 1'b1;
                @(negedge clk);
                clr_overflow = 1'b0;
            end
        end

        ready_mode = 1;
        for (int i = 0; i < 200 && (sb_q.size() != 0 || pend_q.size() != 0); i++) @(negedge clk);
        chk("final_drain", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Serial receiver for the SoC's UART transmit line (io_uart_txd), consumed directly downstream of the Murax top level.
- Decodes 8N1 frames and buffers the received bytes in a small FIFO with a valid/ready output.
- Used by the on-board self-check and loopback logic, which compare what the CPU prints against expected bytes and drive status LEDs.
- Single clock domain (the main clock); the rxd input is asynchronous and is synchronised internally.

Parameters:
CLKS_PER_BIT, 104, clock cycles per UART bit (12 MHz / 115200); must be even and >= 4
FIFO_DEPTH, 4, FIFO entries; power of two, >= 2
LEVEL_W, 3, width of level output; must be log2(FIFO_DEPTH)+1

Ports:
clk  input  1  main clock
resetn  input  1  synchronous active-low reset
rxd  input  1  asynchronous serial input, idle high
out_data  output  8  FIFO head byte
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts head when high with out_valid
frame_err  output  1  one-cycle pulse: stop bit sampled low
overflow  output  1  sticky: a good byte was dropped because the FIFO was full
clr_overflow  input  1  clears overflow (synchronous)
level  output  LEVEL_W  current FIFO occupancy

Behaviour:
- Reset is sampled on clk only; resetn low for one edge is sufficient.
- Reset values:
  - Synchroniser flops 1.
  - FSM IDLE; counters 0; FIFO empty.
  - out_valid 0, out_data 0, level 0, frame_err 0, overflow 0.
- Reset mid-frame abandons the frame: no push, no frame_err.
- Synchroniser: rxd passes two flops to give rxd_s; all FSM decisions use rxd_s.
- Bit counter: cnt counts 0..CLKS_PER_BIT-1.
- FSM:
  - IDLE: when rxd_s==0, go to START with cnt=0.
  - START: cnt increments. At cnt==CLKS_PER_BIT/2-1, sample rxd_s.
    - 0: go to DATA with cnt=0, bit index=0.
    - 1: glitch; return to IDLE with no other effect.
  - DATA: at cnt==CLKS_PER_BIT-1, sample rxd_s into the shift register, LSB first. cnt resets and bit index increments. After the 8th sample, go to STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, sample rxd_s.
    - 1: push the byte, then go to IDLE.
    - 0: frame_err=1 for exactly that cycle, byte discarded, then go to IDLE.
    - IDLE then waits for rxd_s low, so a line held low after a framing error restarts reception immediately.
- Latency: with edge E = first clk edge at which the rxd pin is sampled low, out_valid rises after edge E + 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT, given an empty FIFO. For CLKS_PER_BIT=8 this is edge E+78, so out_valid is visible in the cycle after it.
- FIFO:
  - out_data is the head entry, registered; it is stable while out_valid is high and not popped.
  - Pop occurs when out_valid && out_ready.
  - Push while not full: accepted.
  - Push while full with a pop in the same cycle: accepted, level unchanged.
  - Push while full without a pop: byte dropped, overflow set.
  - Simultaneous push and pop when not full: level unchanged.
  - Pointers wrap modulo FIFO_DEPTH; level spans 0..FIFO_DEPTH.
  - When the FIFO is empty, out_data holds its last value (don't care).
- overflow:
  - clr_overflow clears it.
  - If a set and a clear occur in the same cycle, set wins.
- The byte being received is unaffected by FIFO state and by out_ready.

Test Plan:
1. CLKS_PER_BIT=8, out_ready=1, send 0xA5 8N1 -> out_valid high for 1 cycle with out_data=0xA5, 78 edges after first low sample; frame_err never pulses; level returns to 0.
2. out_ready=0, send 0x01,0x02,0x03,0x04,0x55 -> level=4, overflow=1, FIFO holds 0x01..0x04. Then out_ready=1 -> bytes drain in order 0x01,0x02,0x03,0x04 on consecutive cycles, with 0x55 absent. Pulse clr_overflow -> overflow=0.
3. Send 0x3C with the stop bit driven low -> frame_err pulses once at the stop sample; level stays 0. Then send 0x7E normally -> 0x7E received.
4. Drive rxd low for 2 cycles, then high -> START aborts at the mid-bit sample; no push, no frame_err. A subsequent 0xFF frame is received correctly.
5. FIFO full (out_ready=0), then assert out_ready in the exact cycle a new byte is pushed -> push accepted, head popped, level stays 4, overflow stays 0.
6. Assert resetn low for 1 cycle mid-DATA of a frame -> all outputs return to reset values; no byte from that frame appears. The next full frame 0x5A is received correctly.
